piso_universal_serializer: RTL and testbench
============================================

Name: piso_universal_serializer

Overview:
Parametrised parallel-in/serial-out shift register. It is the next generation of the team's 4-bit PISO left-shift block. It adds configurable width, per-frame shift direction (MSB-first or LSB-first), a serial fill input, a remaining-bit counter, and busy/valid/done status. It sits between a parallel data source and a 1-bit serial link or serial display chain.

Parameters:
WIDTH, 4, parallel word width in bits (>= 2)
CNT_W, $clog2(WIDTH+1), width of bits_left; derived, do not override

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
load  in  1  parallel-load request
shift  in  1  shift-enable
dir  in  1  direction, sampled at load: 0 = left shift / MSB first, 1 = right shift / LSB first
in  in  WIDTH  parallel data word
serial_in  in  1  fill bit shifted into the vacated end
out  out  1  current serial bit
out_valid  out  1  out carries a frame bit
busy  out  1  frame in progress
done  out  1  one-cycle pulse after the last bit of a frame has been shifted out
bits_left  out  CNT_W  frame bits not yet shifted out

Behaviour:
- State: sr[WIDTH-1:0], cnt[CNT_W-1:0], dir_q, busy, done. All are registered.
- Reset (async, high): sr=0, cnt=0, dir_q=0, busy=0, done=0. As a result out=0, out_valid=0, bits_left=0 immediately, without waiting for a clock edge. Reset mid-frame aborts the frame and does not pulse done.
- Outputs:
  - out = busy ? (dir_q ? sr[0] : sr[WIDTH-1]) : 0. This is combinational from registers.
  - out_valid = busy.
  - bits_left = cnt.
- Each rising edge, in priority order:
  1. load=1, shift=0: sr<=in, cnt<=WIDTH, dir_q<=dir, busy<=1, done<=0. Load is accepted when idle or busy. A load while busy aborts the current frame with no done pulse.
  2. load=1, shift=1: hold all state, done<=0. This keeps the legacy "both asserted = retain" behaviour.
  3. load=0, shift=1, busy=1:
     - dir_q=0: sr<={sr[WIDTH-2:0],serial_in}.
     - dir_q=1: sr<={serial_in,sr[WIDTH-1:1]}.
     - cnt<=cnt-1.
     - If cnt==1: busy<=0, done<=1. Otherwise done<=0.
  4. load=0, shift=1, busy=0: ignored; hold, done<=0.
  5. load=0, shift=0: hold, done<=0.
- Latency:
  - First frame bit is on out in the cycle after the load edge.
  - Bit k (0-based) is on out after k accepted shifts.
  - A frame takes 1 load cycle plus WIDTH shift cycles.
- done is high for exactly one cycle, in the cycle after the edge that consumed the last bit. A load arriving in that cycle is legal and clears done on the next edge.
- dir and in changes while busy have no effect until the next load.
- Gaps in shift stall the frame indefinitely with no loss of bits.
- serial_in bits never appear on out within a frame. They only fill sr.

Test Plan:
1. WIDTH=4: assert reset, release; load in=1011 dir=0 for 1 cycle, then shift=1 continuously -> out=1,0,1,1 on successive cycles; bits_left=4,3,2,1,0; busy falls and done=1 for exactly one cycle after the 4th shift edge; out=0 afterwards.
2. WIDTH=4: load in=1011 dir=1, shift=1 -> out=1,1,0,1; done pulse as in 1. WIDTH=8: load 8'hA5 dir=0 -> out=1,0,1,0,0,1,0,1.
3. Mid-frame (bits_left=2), assert load=1 and shift=1 for 2 cycles -> out, bits_left and busy are unchanged; the frame then completes normally with no extra or missing bits.
4. Mid-frame, drop shift for 3 cycles; toggle dir and in meanwhile -> state holds, the remaining bits emerge in the original order, and dir_q is unchanged.
5. Mid-frame (bits_left=3), load 0110 dir=0 -> bits_left=4, out sequence 0,1,1,0; exactly one done pulse, for the second frame only.
6. Mid-frame, assert reset between clock edges -> out, out_valid, busy and bits_left go to 0 before the next edge; no done pulse; shift pulses while idle leave out=0.

Source files
------------

// File: rtl/piso_universal_serializer.sv
// Parallel-in/serial-out shift register with selectable bit order per frame,
// serial fill, remaining-bit count and busy/valid/done status.
module piso_universal_serializer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic             dir,
    input  logic [WIDTH-1:0] in,
    input  logic             serial_in,
    output logic             out,
    output logic             out_valid,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] bits_left
);

    logic [WIDTH-1:0] sr;
    logic [CNT_W-1:0] cnt;
    logic             dirQ;

    // Load wins over shift unless both are high, which retains the frame as-is.
    // done defaults low every edge so it can only ever be a single-cycle pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sr   <= '0;
            cnt  <= '0;
            dirQ <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load && !shift) begin
                sr   <= in;
                cnt  <= CNT_W'(WIDTH);
                dirQ <= dir;
                busy <= 1'b1;
            end else if (!load && shift && busy) begin
                if (dirQ) begin
                    sr <= {serial_in, sr[WIDTH-1:1]};
                end else begin
                    sr <= {sr[WIDTH-2:0], serial_in};
                end
                cnt <= cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    // The outgoing bit sits at whichever end the frame shifts towards.
    assign out       = busy ? (dirQ ? sr[0] : sr[WIDTH-1]) : 1'b0;
    assign out_valid = busy;
    assign bits_left = cnt;

endmodule

// File: tb/tb_piso_universal_serializer.sv
// Scoreboard bench driving a 4-bit and an 8-bit serializer in lockstep and
// comparing every cycle against queues of expected frame bits.
module tb_piso_universal_serializer;

    logic       clock = 1'b0;
    logic       reset;
    logic       load, shift, dir, serialIn;
    logic [3:0] data4;
    logic [7:0] data8;

    logic       out4, valid4, busy4, done4;
    logic [2:0] left4;
    logic       out8, valid8, busy8, done8;
    logic [3:0] left8;

    int   checks = 0;
    int   errors = 0;
    logic q4[$];
    logic q8[$];
    logic expDone4 = 1'b0;
    logic expDone8 = 1'b0;

    always #5 clock = ~clock;

    piso_universal_serializer #(.WIDTH(4)) dut4 (
        .clock(clock), .reset(reset), .load(load), .shift(shift), .dir(dir),
        .in(data4), .serial_in(serialIn), .out(out4), .out_valid(valid4),
        .busy(busy4), .done(done4), .bits_left(left4)
    );

    piso_universal_serializer #(.WIDTH(8)) dut8 (
        .clock(clock), .reset(reset), .load(load), .shift(shift), .dir(dir),
        .in(data8), .serial_in(serialIn), .out(out8), .out_valid(valid8),
        .busy(busy8), .done(done8), .bits_left(left8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare both DUTs against the head of their scoreboard queues.
    task automatic checkOutput(input string tag);
        chk({tag, "/out4"},   32'(out4),   32'(q4.size() > 0 ? q4[0] : 1'b0));
        chk({tag, "/valid4"}, 32'(valid4), 32'(q4.size() > 0));
        chk({tag, "/busy4"},  32'(busy4),  32'(q4.size() > 0));
        chk({tag, "/left4"},  32'(left4),  32'(q4.size()));
        chk({tag, "/done4"},  32'(done4),  32'(expDone4));
        chk({tag, "/out8"},   32'(out8),   32'(q8.size() > 0 ? q8[0] : 1'b0));
        chk({tag, "/valid8"}, 32'(valid8), 32'(q8.size() > 0));
        chk({tag, "/busy8"},  32'(busy8),  32'(q8.size() > 0));
        chk({tag, "/left8"},  32'(left8),  32'(q8.size()));
        chk({tag, "/done8"},  32'(done8),  32'(expDone8));
    endtask

    task automatic applyStimulus(input string tag, input logic ld, input logic sh,
                                 input logic dr, input logic [3:0] d4,
                                 input logic [7:0] d8, input logic si);
        load = ld; shift = sh; dir = dr; data4 = d4; data8 = d8; serialIn = si;
        @(posedge clock);
        if (ld && !sh) begin
            q4.delete();
            q8.delete();
            for (int i = 0; i < 4; i++) q4.push_back(dr ? d4[i] : d4[3-i]);
            for (int i = 0; i < 8; i++) q8.push_back(dr ? d8[i] : d8[7-i]);
            expDone4 = 1'b0;
            expDone8 = 1'b0;
        end else if (!ld && sh) begin
            expDone4 = 1'b0;
            expDone8 = 1'b0;
            if (q4.size() > 0) begin
                void'(q4.pop_front());
                expDone4 = (q4.size() == 0);
            end
            if (q8.size() > 0) begin
                void'(q8.pop_front());
                expDone8 = (q8.size() == 0);
            end
        end else begin
            expDone4 = 1'b0;
            expDone8 = 1'b0;
        end
        #1;
        checkOutput(tag);
    endtask

    initial begin
        reset = 1'b1; load = 0; shift = 0; dir = 0; serialIn = 0; data4 = 0; data8 = 0;
        repeat (2) @(posedge clock);
        #1;
        checkOutput("reset");
        reset = 1'b0;

        // MSB-first frames with serial fill of ones, plus idle shifts afterwards
        applyStimulus("msbLoad", 1, 0, 0, 4'b1011, 8'hA5, 1);
        for (int i = 0; i < 10; i++) applyStimulus("msbShift", 0, 1, 0, 4'b0000, 8'h00, 1);
        chk("msbIdleOut4", 32'(out4), 32'd0);

        // LSB-first frames; load lands in the done cycle of the 4-bit frame
        applyStimulus("lsbLoad", 1, 0, 1, 4'b1011, 8'h3C, 0);
        for (int i = 0; i < 4; i++) applyStimulus("lsbShift", 0, 1, 0, 4'b0101, 8'hFF, 1);
        applyStimulus("loadInDone", 1, 0, 0, 4'b1011, 8'hC3, 0);
        chk("loadInDoneLeft4", 32'(left4), 32'd4);
        applyStimulus("afterDone", 0, 0, 0, 4'b0000, 8'h00, 0);

        // Both load and shift high retains the frame mid-way
        applyStimulus("retShift", 0, 1, 1, 4'b1111, 8'hFF, 0);
        applyStimulus("retShift", 0, 1, 1, 4'b1111, 8'hFF, 0);
        chk("retLeft4", 32'(left4), 32'd2);
        applyStimulus("retain", 1, 1, 1, 4'b0110, 8'h5A, 1);
        applyStimulus("retain", 1, 1, 1, 4'b0110, 8'h5A, 1);
        for (int i = 0; i < 3; i++) applyStimulus("retShift", 0, 1, 1, 4'b0000, 8'h00, 0);

        // Stall with dir and data toggling, then finish the 8-bit frame
        for (int i = 0; i < 3; i++) applyStimulus("stall", 0, 0, i[0], 4'(i * 5), 8'(i * 77), i[0]);
        for (int i = 0; i < 4; i++) applyStimulus("stallShift", 0, 1, 1, 4'b1001, 8'h99, 1);

        // Reload while the 4-bit frame has three bits left
        applyStimulus("preLoad", 1, 0, 1, 4'b1100, 8'h81, 0);
        applyStimulus("preShift", 0, 1, 0, 4'b0000, 8'h00, 1);
        chk("preLeft4", 32'(left4), 32'd3);
        applyStimulus("reload", 1, 0, 0, 4'b0110, 8'h6E, 1);
        for (int i = 0; i < 9; i++) applyStimulus("reloadShift", 0, 1, 1, 4'b1111, 8'hFF, 1);

        // Asynchronous reset in the middle of a frame
        applyStimulus("rstLoad", 1, 0, 0, 4'b1111, 8'hFF, 0);
        applyStimulus("rstShift", 0, 1, 0, 4'b0000, 8'h00, 0);
        reset = 1'b1;
        q4.delete();
        q8.delete();
        expDone4 = 1'b0;
        expDone8 = 1'b0;
        #1;
        checkOutput("asyncReset");
        #2;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus("idleShift", 0, 1, 0, 4'b1111, 8'hFF, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
